// File: rtl/s2mm_cmd_arbiter_if.sv
// s2mm_cmd_arbiter_if: command, status and control signals between two S2MM requesters and a shared datamover.
interface s2mm_cmd_arbiter_if;
    logic [71:0] s0_cmd_tdata;
    logic        s0_cmd_tvalid;
    logic        s0_cmd_tready;
    logic [71:0] s1_cmd_tdata;
    logic        s1_cmd_tvalid;
    logic        s1_cmd_tready;
    logic [71:0] m_cmd_tdata;
    logic        m_cmd_tvalid;
    logic        m_cmd_tready;
    logic [7:0]  s_sts_tdata;
    logic        s_sts_tvalid;
    logic        s_sts_tready;
    logic [7:0]  m0_sts_tdata;
    logic        m0_sts_tvalid;
    logic        m0_sts_tready;
    logic [7:0]  m1_sts_tdata;
    logic        m1_sts_tvalid;
    logic        m1_sts_tready;
    logic        err_sticky;
    logic        err_clr;
    logic [7:0]  arb_status;

    modport slave (
        input  s0_cmd_tdata, s0_cmd_tvalid, s1_cmd_tdata, s1_cmd_tvalid, m_cmd_tready,
        input  s_sts_tdata, s_sts_tvalid, m0_sts_tready, m1_sts_tready, err_clr,
        output s0_cmd_tready, s1_cmd_tready, m_cmd_tdata, m_cmd_tvalid,
        output s_sts_tready, m0_sts_tdata, m0_sts_tvalid, m1_sts_tdata, m1_sts_tvalid,
        output err_sticky, arb_status
    );

    modport master (
        output s0_cmd_tdata, s0_cmd_tvalid, s1_cmd_tdata, s1_cmd_tvalid, m_cmd_tready,
        output s_sts_tdata, s_sts_tvalid, m0_sts_tready, m1_sts_tready, err_clr,
        input  s0_cmd_tready, s1_cmd_tready, m_cmd_tdata, m_cmd_tvalid,
        input  s_sts_tready, m0_sts_tdata, m0_sts_tvalid, m1_sts_tdata, m1_sts_tvalid,
        input  err_sticky, arb_status
    );
endinterface

// File: rtl/s2mm_cmd_arbiter.sv
// s2mm_cmd_arbiter: round-robin sharing of one S2MM datamover between two requesters,
// with per-requester outstanding limits, tag rewriting and status routing back by tag.
module s2mm_cmd_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    s2mm_cmd_arbiter_if.slave  bus_io
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2} state_t;

    localparam logic [2:0]  MAX      = 3'(MAX_OUT);
    localparam logic [71:0] TAG_MASK = {4'h0, 4'hF, 64'h0};

    state_t      state_q;
    logic        gnt_q, last_grant_q;
    logic        s0_rdy_q, s1_rdy_q;
    logic        m_valid_q;
    logic [71:0] m_data_q;
    logic [2:0]  seq0_q, seq1_q;
    logic [2:0]  out0_q, out1_q, out0_d, out1_d;
    logic        buf_valid_q, buf_port_q;
    logic [7:0]  buf_data_q;
    logic        err_q, err_d;

    logic        elig0, elig1, gnt_d;
    logic        sel_valid, issue;
    logic [71:0] sel_data;
    logic [2:0]  sel_seq;
    logic        sts_hs, sts_port, orphan, dec0, dec1;

    always_comb begin
        elig0     = bus_io.s0_cmd_tvalid && (out0_q < MAX);
        elig1     = bus_io.s1_cmd_tvalid && (out1_q < MAX);
        gnt_d     = (elig0 && elig1) ? ~last_grant_q : elig1;
        sel_valid = gnt_q ? bus_io.s1_cmd_tvalid : bus_io.s0_cmd_tvalid;
        sel_data  = gnt_q ? bus_io.s1_cmd_tdata : bus_io.s0_cmd_tdata;
        sel_seq   = gnt_q ? seq1_q : seq0_q;
        issue     = (state_q == ISSUE) && sel_valid;
        sts_hs    = bus_io.s_sts_tvalid && !buf_valid_q;
        sts_port  = bus_io.s_sts_tdata[3];
        orphan    = sts_port ? (out1_q == 3'd0) : (out0_q == 3'd0);
        dec0      = buf_valid_q && !buf_port_q && bus_io.m0_sts_tready;
        dec1      = buf_valid_q && buf_port_q && bus_io.m1_sts_tready;
        // a status is only ever buffered against a non-zero counter, so dec cannot underflow
        out0_d    = out0_q + {2'b0, issue && !gnt_q} - {2'b0, dec0};
        out1_d    = out1_q + {2'b0, issue && gnt_q} - {2'b0, dec1};
        err_d     = (sts_hs && (|bus_io.s_sts_tdata[6:4] || orphan)) || (err_q && !bus_io.err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            s0_rdy_q     <= 1'b0;
            s1_rdy_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            seq0_q       <= '0;
            seq1_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (elig0 || elig1) begin
                    gnt_q    <= gnt_d;
                    s0_rdy_q <= !gnt_d;
                    s1_rdy_q <= gnt_d;
                    state_q  <= ISSUE;
                end
                ISSUE: begin
                    s0_rdy_q <= 1'b0;
                    s1_rdy_q <= 1'b0;
                    // a requester that withdrew its command is skipped without side effects
                    if (sel_valid) begin
                        m_data_q     <= (sel_data & ~TAG_MASK) | {4'h0, gnt_q, sel_seq, 64'h0};
                        m_valid_q    <= 1'b1;
                        last_grant_q <= gnt_q;
                        if (gnt_q) seq1_q <= seq1_q + 3'd1;
                        else       seq0_q <= seq0_q + 3'd1;
                        state_q      <= WAIT_ACK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_ACK: if (bus_io.m_cmd_tready) begin
                    m_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out0_q      <= '0;
            out1_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_port_q  <= 1'b0;
            buf_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
            err_q  <= err_d;
            if (sts_hs && !orphan) begin
                buf_valid_q <= 1'b1;
                buf_port_q  <= sts_port;
                buf_data_q  <= bus_io.s_sts_tdata;
            end else if (dec0 || dec1) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

    assign bus_io.s0_cmd_tready = s0_rdy_q;
    assign bus_io.s1_cmd_tready = s1_rdy_q;
    assign bus_io.m_cmd_tvalid  = m_valid_q;
    assign bus_io.m_cmd_tdata   = m_data_q;
    assign bus_io.s_sts_tready  = !buf_valid_q;
    assign bus_io.m0_sts_tvalid = buf_valid_q && !buf_port_q;
    assign bus_io.m1_sts_tvalid = buf_valid_q && buf_port_q;
    assign bus_io.m0_sts_tdata  = buf_data_q;
    assign bus_io.m1_sts_tdata  = buf_data_q;
    assign bus_io.err_sticky    = err_q;
    assign bus_io.arb_status    = {state_q, last_grant_q, 1'b0, out0_q[1:0], out1_q[1:0]};
endmodule

// File: tb/tb_s2mm_cmd_arbiter.sv
// tb_s2mm_cmd_arbiter: directed checks of arbitration, tag rewrite, backpressure, status routing and reset.
module tb_s2mm_cmd_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] C0_LO = 64'h8000_0000_4080_0400;
    localparam logic [63:0] C1_LO = 64'h1234_5678_8000_0010;

    s2mm_cmd_arbiter_if bus ();

    s2mm_cmd_arbiter #(.MAX_OUT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic expect_cmd(input string name, input logic [71:0] exp);
        int n = 0;
        while (bus.m_cmd_tvalid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 72'(n), 72'd2);
        chk(name, bus.m_cmd_tdata, exp);
    endtask

    initial begin
        logic [71:0] exp_stream [7];
        exp_stream = '{{4'hA, 4'h8, C1_LO}, {4'h0, 4'h1, C0_LO}, {4'hA, 4'h9, C1_LO},
                       {4'h0, 4'h2, C0_LO}, {4'hA, 4'hA, C1_LO}, {4'h0, 4'h3, C0_LO},
                       {4'hA, 4'hB, C1_LO}};
        rst_n = 1'b0;
        bus.s0_cmd_tdata  = {4'h0, 4'hF, C0_LO};
        bus.s1_cmd_tdata  = {4'hA, 4'h3, C1_LO};
        bus.s0_cmd_tvalid = 1'b0;
        bus.s1_cmd_tvalid = 1'b0;
        bus.m_cmd_tready  = 1'b0;
        bus.s_sts_tdata   = 8'h00;
        bus.s_sts_tvalid  = 1'b0;
        bus.m0_sts_tready = 1'b0;
        bus.m1_sts_tready = 1'b0;
        bus.err_clr       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 72'(bus.m_cmd_tvalid), 72'd0);
        chk("rst_m_data", bus.m_cmd_tdata, 72'd0);
        chk("rst_sts_rdy", 72'(bus.s_sts_tready), 72'd1);
        chk("rst_cmd_rdy", 72'({bus.s0_cmd_tready, bus.s1_cmd_tready}), 72'd0);
        chk("rst_status", 72'(bus.arb_status), 72'h20);
        chk("rst_err", 72'(bus.err_sticky), 72'd0);

        // single request from s0 with tag 0xF, datamover held off
        rst_n = 1'b1;
        bus.s0_cmd_tvalid = 1'b1;
        @(negedge clk);
        chk("single_rdy_pulse", 72'({bus.s0_cmd_tready, bus.s1_cmd_tready}), 72'b10);
        chk("single_valid_early", 72'(bus.m_cmd_tvalid), 72'd0);
        @(negedge clk);
        chk("single_valid", 72'(bus.m_cmd_tvalid), 72'd1);
        chk("single_data", bus.m_cmd_tdata, {4'h0, 4'h0, C0_LO});
        chk("single_rdy_off", 72'(bus.s0_cmd_tready), 72'd0);
        bus.s0_cmd_tvalid = 1'b0;
        bus.s1_cmd_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 72'(bus.m_cmd_tvalid), 72'd1);
            chk("hold_data", bus.m_cmd_tdata, {4'h0, 4'h0, C0_LO});
            chk("hold_no_rdy", 72'({bus.s0_cmd_tready, bus.s1_cmd_tready}), 72'd0);
        end
        chk("hold_status", 72'(bus.arb_status), 72'h84);

        // both continuously valid: alternate until each hits four outstanding
        bus.s0_cmd_tvalid = 1'b1;
        bus.m_cmd_tready  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            expect_cmd($sformatf("stream%0d", i), exp_stream[i]);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("blocked_valid", 72'(bus.m_cmd_tvalid), 72'd0);
            chk("blocked_rdy", 72'({bus.s0_cmd_tready, bus.s1_cmd_tready}), 72'd0);
        end
        chk("blocked_status", 72'(bus.arb_status), 72'h20);

        // status for s0 frees one slot
        bus.s_sts_tdata  = 8'h82;
        bus.s_sts_tvalid = 1'b1;
        @(negedge clk);
        chk("sts0_valid", 72'({bus.m0_sts_tvalid, bus.m1_sts_tvalid}), 72'b10);
        chk("sts0_data", 72'(bus.m0_sts_tdata), 72'h82);
        chk("sts0_full", 72'(bus.s_sts_tready), 72'd0);
        bus.s_sts_tvalid  = 1'b0;
        bus.m0_sts_tready = 1'b1;
        @(negedge clk);
        chk("sts0_drained", 72'(bus.m0_sts_tvalid), 72'd0);
        chk("sts0_status", 72'(bus.arb_status), 72'h2C);
        bus.m0_sts_tready = 1'b0;
        expect_cmd("regrant_s0", {4'h0, 4'h4, C0_LO});
        @(negedge clk);
        bus.s0_cmd_tvalid = 1'b0;
        bus.s1_cmd_tvalid = 1'b0;

        // SLVERR status routed to s1, then cleared
        bus.m1_sts_tready = 1'b1;
        bus.s_sts_tdata   = 8'h49;
        bus.s_sts_tvalid  = 1'b1;
        @(negedge clk);
        chk("sts1_valid", 72'({bus.m0_sts_tvalid, bus.m1_sts_tvalid}), 72'b01);
        chk("sts1_data", 72'(bus.m1_sts_tdata), 72'h49);
        chk("sts1_err", 72'(bus.err_sticky), 72'd1);
        bus.s_sts_tvalid = 1'b0;
        @(negedge clk);
        chk("sts1_drained", 72'(bus.m1_sts_tvalid), 72'd0);
        chk("sts1_status", 72'(bus.arb_status), 72'h03);
        bus.m1_sts_tready = 1'b0;
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cleared", 72'(bus.err_sticky), 72'd0);

        // reset while a command waits for the datamover and a status is buffered
        bus.s1_cmd_tvalid = 1'b1;
        bus.m_cmd_tready  = 1'b0;
        expect_cmd("pre_reset_s1", {4'hA, 4'hC, C1_LO});
        bus.s1_cmd_tvalid = 1'b0;
        bus.s_sts_tdata   = 8'h81;
        bus.s_sts_tvalid  = 1'b1;
        @(negedge clk);
        chk("pre_reset_sts", 72'(bus.m0_sts_tvalid), 72'd1);
        bus.s_sts_tvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", 72'(bus.m_cmd_tvalid), 72'd0);
        chk("mid_rst_m_data", bus.m_cmd_tdata, 72'd0);
        chk("mid_rst_sts_valid", 72'({bus.m0_sts_tvalid, bus.m1_sts_tvalid}), 72'd0);
        chk("mid_rst_sts_data", 72'({bus.m0_sts_tdata, bus.m1_sts_tdata}), 72'd0);
        chk("mid_rst_sts_rdy", 72'(bus.s_sts_tready), 72'd1);
        chk("mid_rst_status", 72'(bus.arb_status), 72'h20);

        // orphan status on s0 with a coincident clear: the set wins
        rst_n = 1'b1;
        bus.s_sts_tdata  = 8'h03;
        bus.s_sts_tvalid = 1'b1;
        bus.err_clr      = 1'b1;
        @(negedge clk);
        chk("orphan_err", 72'(bus.err_sticky), 72'd1);
        chk("orphan_dropped", 72'({bus.m0_sts_tvalid, bus.m1_sts_tvalid}), 72'd0);
        chk("orphan_rdy", 72'(bus.s_sts_tready), 72'd1);
        chk("orphan_status", 72'(bus.arb_status), 72'h20);
        bus.s_sts_tvalid  = 1'b0;
        bus.err_clr       = 1'b0;
        bus.s0_cmd_tvalid = 1'b1;
        bus.s1_cmd_tvalid = 1'b1;
        bus.m_cmd_tready  = 1'b1;
        expect_cmd("post_reset_s0", {4'h0, 4'h0, C0_LO});
        @(negedge clk);
        bus.s0_cmd_tvalid = 1'b0;
        bus.s1_cmd_tvalid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/s2mm_cmd_arbiter.md
S2MM_CMD_ARBITER -- requirements
Module: s2mm_cmd_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 4, SHALL set the maximum number of outstanding (issued, status not yet returned) commands per requester; legal range 1..7.
REQ-002 clk  in  1  clock; all logic SHALL be rising-edge only.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 s0_cmd_tdata/s0_cmd_tvalid/s0_cmd_tready  in/in/out  72/1/1  requester 0 S2MM command (datamover format: rsvd[71:68], tag[67:64], addr[63:32], drr, eof, dsa, type, btt[22:0]).
REQ-005 s1_cmd_tdata/s1_cmd_tvalid/s1_cmd_tready  in/in/out  72/1/1  requester 1 S2MM command, same format.
REQ-006 m_cmd_tdata/m_cmd_tvalid/m_cmd_tready  out/out/in  72/1/1  command to the shared datamover.
REQ-007 s_sts_tdata/s_sts_tvalid/s_sts_tready  in/in/out  8/1/1  datamover status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] tag.
REQ-008 m0_sts_tdata/m0_sts_tvalid/m0_sts_tready  out/out/in  8/1/1  status routed to requester 0.
REQ-009 m1_sts_tdata/m1_sts_tvalid/m1_sts_tready  out/out/in  8/1/1  status routed to requester 1.
REQ-010 err_sticky  out  1  set on any status with bit 6, 5 or 4 set, or on an orphan status.
REQ-011 err_clr  in  1  single-cycle pulse; clears err_sticky.
REQ-012 arb_status  out  8  {state[1:0], last_grant, 1'b0, out0[1:0], out1[1:0]} (low bits of outstanding counters).

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_ACK.
REQ-014 IDLE: requester i is eligible when si_cmd_tvalid=1 and out_i < MAX_OUT; if any are eligible, grant SHALL be round-robin (the requester not equal to last_grant wins ties; after reset last_grant=1, so requester 0 wins first), and the next state SHALL be ISSUE.
REQ-015 ISSUE (one cycle): the command SHALL be latched into the m_cmd register with tag[67:64] replaced by {grant_id, seq_i[2:0]}, all other bits passed through unchanged; si_cmd_tready SHALL pulse high for exactly this cycle for the granted requester only; m_cmd_tvalid SHALL go high on the next cycle; seq_i SHALL increment (3-bit wrap 7->0); out_i SHALL increment; last_grant SHALL be updated; next state SHALL be WAIT_ACK.
REQ-016 WAIT_ACK: m_cmd_tvalid and m_cmd_tdata SHALL be held stable until m_cmd_tready=1; on handshake, m_cmd_tvalid SHALL drop on the next cycle and the state SHALL return to IDLE.
REQ-017 Minimum spacing between m_cmd handshakes SHALL be 3 cycles; latency from an eligible tvalid in IDLE to m_cmd_tvalid SHALL be 2 cycles.
REQ-018 si_cmd_tready SHALL be 0 in every cycle other than REQ-015.
REQ-019 Status path: a one-entry buffer SHALL be used; s_sts_tready = ~buf_valid; on s_sts handshake, tdata SHALL be captured and routed to port tag[3].
REQ-020 A buffered status SHALL drive mK_sts_tvalid=1 with tdata unchanged (original tag) until mK_sts_tready=1; the buffer SHALL empty on that handshake. The other port's tvalid SHALL stay 0.
REQ-021 out_K SHALL decrement on the mK_sts handshake; a simultaneous increment (REQ-015) and decrement on the same counter SHALL leave it unchanged.
REQ-022 An orphan status (out_K==0 at capture) SHALL be accepted and dropped without any mK_sts_tvalid, and SHALL set err_sticky; out_K SHALL stay 0 (no underflow).
REQ-023 err_sticky SHALL set one cycle after the s_sts handshake for an error or orphan status; if err_clr and a new set event occur in the same cycle, set SHALL win.
REQ-024 A requester deasserting tvalid in IDLE before grant SHALL simply not be granted; the arbiter SHALL not latch or issue data from a non-valid port.

Reset
REQ-025 While rst_n=0, at the next edge: state=IDLE; all tvalid and tready outputs=0 except s_sts_tready=1 (buffer empty); m_cmd_tdata=0; m0/m1_sts_tdata=0; out0=out1=0; seq0=seq1=0; last_grant=1; err_sticky=0.
REQ-026 Reset asserted mid-handshake SHALL abandon the pending command and buffered status with no further output activity; counters SHALL restart from 0.

Verification
REQ-027 Single request: s0 cmd addr=0x8000_0000, btt=0x400, tag field 0xF -> m_cmd_tvalid 2 cycles later, tag=0x0, other bits identical; s0_cmd_tready pulses once.
REQ-028 Both requesters continuously valid, m_cmd_tready=1 -> grants alternate 0,1,0,1; tags 0x0,0x8,0x1,0x9.
REQ-029 MAX_OUT=4, no status returned -> s0 granted 4 times, then blocked; s1 keeps being granted up to 4; a returned status with tag 0x2 -> m0_sts_tvalid asserted, out0 3, s0 eligible again.
REQ-030 m_cmd_tready held 0 for 10 cycles -> m_cmd_tdata/tvalid stable throughout; no further si_cmd_tready pulses.
REQ-031 Status 0x49 (SLVERR, tag 9) with out1=1 -> delivered on m1, err_sticky=1; err_clr -> 0; status tag 0x3 with out0=0 -> dropped, err_sticky=1.
REQ-032 rst_n low during WAIT_ACK with sts buffered -> all outputs at REQ-025 values next cycle; first post-reset grant goes to requester 0 with tag 0x0.
